feedback_loop_sequencer: RTL and testbench
==========================================

Name: feedback_loop_sequencer

Overview:
Sequences the gyro closed-loop feedback step generator.
- Generates the per-modulation-period integration trigger.
- Controls feedback enable (fb_ON): open-loop settle, then closed loop.
- Schedules the loop gain: starts at a high gain (small shift) and steps toward the final tracking gain.
- Monitors the demodulated error and falls back to acquisition on loss of lock.
- Sits between the register file / demodulator and the feedback step generator.

Parameters:
PER_W, 16, width of modulation period and trigger delay
DWELL_W, 16, width of dwell count (triggers per gain step)
SETTLE_TRIG, 64, triggers spent open-loop after enable before feedback is turned on
RELOCK_W, 8, width of saturating relock event counter

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  loop run request, level
i_mod_period  in  PER_W  modulation period in clocks; values 0 and 1 are treated as 2
i_trig_dly  in  PER_W  phase within period at which o_trig fires
i_gain_init  in  4  initial shift index (high gain)
i_gain_final  in  4  final shift index (tracking gain)
i_dwell  in  DWELL_W  triggers per gain step; 0 is treated as 1
i_err  in  32  signed demodulated error, same sample fed to the step generator
i_unlock_th  in  32  unsigned |err| threshold
i_unlock_cnt  in  8  consecutive over-threshold triggers needed to declare unlock; 0 is treated as 1
o_trig  out  1  one-clock integration strobe
o_fb_ON  out  1  feedback enable to the step generator
o_gain_sel  out  4  shift index to the step generator
o_locked  out  1  high in TRACK
o_state  out  2  FSM state: IDLE=0, SETTLE=1, ACQ=2, TRACK=3
o_relock_cnt  out  RELOCK_W  count of TRACK->ACQ fallbacks, saturating

Behaviour:
Reset values: all outputs 0 except o_gain_sel=i_gain_init sampled after reset. Internal counters are cleared.

Phase counter:
- Runs only while i_enable=1. While disabled it is held at 0.
- Counts 0..P-1, where P=max(i_mod_period,2), then wraps to 0.
- A change to i_mod_period takes effect at the next wrap. The current period is latched at count 0.
- o_trig is registered and pulses exactly one clock after phase==i_trig_dly.
- If i_trig_dly>=P, no trigger is generated.
- Each trigger is one "tick" for all FSM counting.

FSM (registered, transitions on ticks unless stated):
- IDLE:
  - fb_ON=0, gain_sel=i_gain_init, locked=0, dwell and settle counters cleared.
  - i_enable=1 -> SETTLE on the next clock.
- SETTLE:
  - fb_ON=0.
  - After SETTLE_TRIG ticks -> ACQ. fb_ON rises in the same cycle the state becomes ACQ.
- ACQ:
  - fb_ON=1, starting with gain_sel=i_gain_init.
  - Every D=max(i_dwell,1) ticks: if gain_sel<i_gain_final, gain_sel+1 and the dwell counter restarts; otherwise -> TRACK.
  - If i_gain_init>=i_gain_final, gain_sel stays at i_gain_init and the FSM enters TRACK after the first D ticks.
  - gain_sel never decrements in ACQ.
- TRACK:
  - fb_ON=1, gain_sel holds, locked=1.
  - On each tick, evaluate |i_err|>i_unlock_th (unsigned compare). |err| of -2^31 saturates to 2^31-1.
  - Over-threshold ticks increment a consecutive counter; an in-threshold tick clears it.
  - When the counter reaches max(i_unlock_cnt,1): go to ACQ, gain_sel=i_gain_init, locked=0, o_relock_cnt+1 (saturating at all ones).
  - fb_ON stays 1 through this transition, so the integrator is not cleared.
- Any state with i_enable=0: next clock -> IDLE, fb_ON=0 (this clears the step generator's integrator). Disable has priority over every other transition in the same cycle.

Other rules:
- i_enable re-asserted in the same cycle the FSM enters IDLE: the FSM spends one cycle in IDLE, then goes to SETTLE.
- A tick that coincides with a state entry is counted by the new state.
- o_relock_cnt clears only on reset.
- Configuration inputs are sampled live. Changing i_gain_final in TRACK does not leave TRACK. A change takes effect the next time the FSM passes through ACQ.

Test Plan:
- Trigger timing: P=10, trig_dly=3, enable → o_trig pulses at clocks where phase=4 (1-cycle late), spacing 10; trig_dly=12 → no pulses; P=0 → spacing 2.
- Startup sequence: SETTLE_TRIG=64, P=8, trig_dly=0, init=2, final=6, dwell=4 → fb_ON rises after 64 ticks; gain_sel 2,3,4,5,6 each held 4 ticks; after a further 4 ticks at 6, state=3 and locked=1.
- Init≥final: init=7, final=5, dwell=3 → ACQ with gain_sel=7 for 3 ticks → TRACK, gain_sel=7.
- Unlock: TRACK, th=1000, unlock_cnt=3; err=+1500,-2000,+500,+1500,-1001,-32'h80000000 → unlock on the 6th tick only; gain_sel=init, fb_ON stays 1, relock_cnt=1.
- Disable mid-ACQ: drop i_enable → next clock state=0, fb_ON=0, gain_sel=init, phase counter 0, no o_trig; re-enable → full SETTLE repeats.
- Reset mid-TRACK: assert i_rst_n=0 asynchronously → all outputs 0 immediately except gain_sel; relock_cnt=0; relock saturation: 256 forced unlocks with RELOCK_W=8 → stays 255.

Source files
------------

// File: rtl/feedback_loop_sequencer.sv
// Sequencer for the gyro closed-loop feedback step generator: modulation-period
// trigger, open-loop settle, gain-schedule acquisition, tracking and lock-loss fallback.
module feedback_loop_sequencer #(
  parameter int PER_W       = 16,
  parameter int DWELL_W     = 16,
  parameter int SETTLE_TRIG = 64,
  parameter int RELOCK_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [PER_W-1:0]    i_mod_period,
  input  logic [PER_W-1:0]    i_trig_dly,
  input  logic [3:0]          i_gain_init,
  input  logic [3:0]          i_gain_final,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic [31:0]         i_err,
  input  logic [31:0]         i_unlock_th,
  input  logic [7:0]          i_unlock_cnt,
  output logic                o_trig,
  output logic                o_fb_ON,
  output logic [3:0]          o_gain_sel,
  output logic                o_locked,
  output logic [1:0]          o_state,
  output logic [RELOCK_W-1:0] o_relock_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACQ    = 2'd2,
    TRACK  = 2'd3
  } state_t;

  localparam int SET_W = (SETTLE_TRIG > 1) ? $clog2(SETTLE_TRIG) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_TRIG - 1);

  logic [PER_W-1:0]    phase_q;
  logic [PER_W-1:0]    period_q;
  logic [PER_W-1:0]    period_in;
  logic [PER_W-1:0]    period_cur;
  logic                trig_q;

  state_t              state_q, state_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [3:0]          gain_q, gain_d;
  logic [7:0]          unl_q, unl_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;

  logic [DWELL_W-1:0]  dwell_eff;
  logic [7:0]          unl_need;
  logic [8:0]          unl_inc;
  logic [31:0]         err_abs;
  logic                over_th;

  // The period only changes at a wrap: phase 0 takes the live input, later counts use the latched copy.
  assign period_in  = (i_mod_period < PER_W'(2)) ? PER_W'(2) : i_mod_period;
  assign period_cur = (phase_q == '0) ? period_in : period_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q  <= '0;
      period_q <= PER_W'(2);
      trig_q   <= 1'b0;
    end else if (!i_enable) begin
      phase_q  <= '0;
      trig_q   <= 1'b0;
    end else begin
      period_q <= period_cur;
      trig_q   <= (phase_q == i_trig_dly);
      phase_q  <= (phase_q == period_cur - PER_W'(1)) ? '0 : phase_q + PER_W'(1);
    end
  end

  assign dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
  assign unl_need  = (i_unlock_cnt == 8'd0) ? 8'd1 : i_unlock_cnt;
  assign unl_inc   = {1'b0, unl_q} + 9'd1;

  // The most negative error has no positive twin, so it saturates to the largest positive value.
  assign err_abs = !i_err[31]                 ? i_err :
                   (i_err == 32'h8000_0000)   ? 32'h7fff_ffff :
                                                (~i_err + 32'd1);
  assign over_th = (err_abs > i_unlock_th);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      dwell_q  <= '0;
      gain_q   <= '0;
      unl_q    <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      gain_q   <= gain_d;
      unl_q    <= unl_d;
      relock_q <= relock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    gain_d   = gain_q;
    unl_d    = unl_q;
    relock_d = relock_q;

    if (!i_enable) begin
      state_d  = IDLE;
      settle_d = '0;
      dwell_d  = '0;
      unl_d    = '0;
      gain_d   = i_gain_init;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = '0;
          dwell_d  = '0;
          unl_d    = '0;
          gain_d   = i_gain_init;
        end
        SETTLE: begin
          if (trig_q) begin
            if (settle_q == SET_LAST) begin
              state_d  = ACQ;
              settle_d = '0;
              dwell_d  = '0;
              gain_d   = i_gain_init;
            end else begin
              settle_d = settle_q + SET_W'(1);
            end
          end
        end
        ACQ: begin
          if (trig_q) begin
            if (dwell_q >= dwell_eff - DWELL_W'(1)) begin
              dwell_d = '0;
              if (gain_q < i_gain_final) begin
                gain_d = gain_q + 4'd1;
              end else begin
                state_d = TRACK;
                unl_d   = '0;
              end
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end
        end
        TRACK: begin
          // Falling back to ACQ keeps feedback on so the integrator state survives the relock.
          if (trig_q) begin
            if (over_th) begin
              if (unl_inc >= {1'b0, unl_need}) begin
                state_d = ACQ;
                gain_d  = i_gain_init;
                dwell_d = '0;
                unl_d   = '0;
                if (relock_q != {RELOCK_W{1'b1}}) begin
                  relock_d = relock_q + RELOCK_W'(1);
                end
              end else begin
                unl_d = unl_inc[7:0];
              end
            end else begin
              unl_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_trig       = trig_q;
  assign o_fb_ON      = (state_q == ACQ) || (state_q == TRACK);
  assign o_locked     = (state_q == TRACK);
  assign o_state      = state_q;
  assign o_relock_cnt = relock_q;
  assign o_gain_sel   = ((state_q == IDLE) || (state_q == SETTLE)) ? i_gain_init : gain_q;

endmodule

// File: tb/tb_feedback_loop_sequencer.sv
// Directed bench for feedback_loop_sequencer: trigger timing, startup schedule,
// unlock fallback, disable, relock saturation and asynchronous reset.
module tb_feedback_loop_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic [15:0] i_mod_period;
  logic [15:0] i_trig_dly;
  logic [3:0]  i_gain_init;
  logic [3:0]  i_gain_final;
  logic [15:0] i_dwell;
  logic [31:0] i_err;
  logic [31:0] i_unlock_th;
  logic [7:0]  i_unlock_cnt;
  logic        o_trig;
  logic        o_fb_ON;
  logic [3:0]  o_gain_sel;
  logic        o_locked;
  logic [1:0]  o_state;
  logic [7:0]  o_relock_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] err_vec [6];

  feedback_loop_sequencer #(
    .PER_W(16), .DWELL_W(16), .SETTLE_TRIG(64), .RELOCK_W(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_mod_period(i_mod_period), .i_trig_dly(i_trig_dly),
    .i_gain_init(i_gain_init), .i_gain_final(i_gain_final), .i_dwell(i_dwell),
    .i_err(i_err), .i_unlock_th(i_unlock_th), .i_unlock_cnt(i_unlock_cnt),
    .o_trig(o_trig), .o_fb_ON(o_fb_ON), .o_gain_sel(o_gain_sel),
    .o_locked(o_locked), .o_state(o_state), .o_relock_cnt(o_relock_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] per, input logic [15:0] dly,
                               input logic [3:0] g_init, input logic [3:0] g_final,
                               input logic [15:0] dwell);
    i_enable     = en;
    i_mod_period = per;
    i_trig_dly   = dly;
    i_gain_init  = g_init;
    i_gain_final = g_final;
    i_dwell      = dwell;
  endtask

  task automatic stepClk();
    @(posedge i_clk);
    #1;
  endtask

  // Steps until n strobes have been seen; the last strobe is visible but not yet consumed.
  task automatic waitTicks(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * 10 + 20) begin
      stepClk();
      cyc++;
      if (o_trig) got++;
    end
    checkOutput("tick_budget", got, n);
  endtask

  initial begin
    err_vec[0] = 32'd1500;
    err_vec[1] = -32'd2000;
    err_vec[2] = 32'd500;
    err_vec[3] = 32'd1500;
    err_vec[4] = -32'd1001;
    err_vec[5] = 32'h8000_0000;

    i_rst_n      = 1'b0;
    i_err        = 32'd0;
    i_unlock_th  = 32'd1000;
    i_unlock_cnt = 8'd3;
    applyStimulus(1'b0, 16'd10, 16'd3, 4'd2, 4'd6, 16'd4);

    #3;
    checkOutput("rst_trig", {31'd0, o_trig}, 32'd0);
    checkOutput("rst_fb", {31'd0, o_fb_ON}, 32'd0);
    checkOutput("rst_gain", {28'd0, o_gain_sel}, 32'd2);
    checkOutput("rst_locked", {31'd0, o_locked}, 32'd0);
    checkOutput("rst_state", {30'd0, o_state}, 32'd0);
    checkOutput("rst_relock", {24'd0, o_relock_cnt}, 32'd0);
    #9 i_rst_n = 1'b1;
    stepClk();
    checkOutput("idle_state", {30'd0, o_state}, 32'd0);

    // Trigger timing: P=10, delay 3 -> strobe on the 4th edge after enable, then every 10
    i_enable = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      stepClk();
      checkOutput("trig_p10", {31'd0, o_trig}, (i == 4 || i == 14 || i == 24) ? 32'd1 : 32'd0);
    end
    checkOutput("settle_state", {30'd0, o_state}, 32'd1);
    checkOutput("settle_fb", {31'd0, o_fb_ON}, 32'd0);

    i_trig_dly = 16'd12;
    for (int i = 1; i <= 20; i++) begin
      stepClk();
      checkOutput("trig_dly_oob", {31'd0, o_trig}, 32'd0);
    end

    // Phase is 4 here; period 0 becomes 2 only after the running 10-count wraps
    i_mod_period = 16'd0;
    i_trig_dly   = 16'd0;
    for (int j = 1; j <= 14; j++) begin
      stepClk();
      checkOutput("trig_p0", {31'd0, o_trig}, (j >= 7 && (j % 2) == 1) ? 32'd1 : 32'd0);
    end

    i_enable = 1'b0;
    stepClk();
    checkOutput("dis_state", {30'd0, o_state}, 32'd0);
    checkOutput("dis_trig", {31'd0, o_trig}, 32'd0);

    // Startup schedule
    applyStimulus(1'b1, 16'd8, 16'd0, 4'd2, 4'd6, 16'd4);
    waitTicks(64);
    checkOutput("su_settle_state", {30'd0, o_state}, 32'd1);
    checkOutput("su_settle_fb", {31'd0, o_fb_ON}, 32'd0);
    stepClk();
    checkOutput("su_acq_state", {30'd0, o_state}, 32'd2);
    checkOutput("su_acq_fb", {31'd0, o_fb_ON}, 32'd1);
    checkOutput("su_acq_gain", {28'd0, o_gain_sel}, 32'd2);
    for (int g = 2; g <= 5; g++) begin
      waitTicks(3);
      checkOutput("su_gain_hold", {28'd0, o_gain_sel}, 32'(g));
      waitTicks(1);
      stepClk();
      checkOutput("su_gain_step", {28'd0, o_gain_sel}, 32'(g + 1));
      checkOutput("su_gain_state", {30'd0, o_state}, 32'd2);
    end
    waitTicks(3);
    checkOutput("su_final_hold", {30'd0, o_state}, 32'd2);
    waitTicks(1);
    stepClk();
    checkOutput("su_track_state", {30'd0, o_state}, 32'd3);
    checkOutput("su_track_locked", {31'd0, o_locked}, 32'd1);
    checkOutput("su_track_gain", {28'd0, o_gain_sel}, 32'd6);
    checkOutput("su_track_fb", {31'd0, o_fb_ON}, 32'd1);

    // Unlock after three consecutive over-threshold ticks
    for (int k = 0; k < 6; k++) begin
      i_err = err_vec[k];
      waitTicks(1);
      stepClk();
      checkOutput("unl_state", {30'd0, o_state}, (k < 5) ? 32'd3 : 32'd2);
    end
    checkOutput("unl_gain", {28'd0, o_gain_sel}, 32'd2);
    checkOutput("unl_fb", {31'd0, o_fb_ON}, 32'd1);
    checkOutput("unl_locked", {31'd0, o_locked}, 32'd0);
    checkOutput("unl_relock", {24'd0, o_relock_cnt}, 32'd1);

    // Disable in ACQ on the very edge a tick is pending
    i_err = 32'd0;
    waitTicks(2);
    i_enable = 1'b0;
    stepClk();
    checkOutput("dacq_state", {30'd0, o_state}, 32'd0);
    checkOutput("dacq_fb", {31'd0, o_fb_ON}, 32'd0);
    checkOutput("dacq_gain", {28'd0, o_gain_sel}, 32'd2);
    checkOutput("dacq_trig", {31'd0, o_trig}, 32'd0);
    checkOutput("dacq_locked", {31'd0, o_locked}, 32'd0);
    applyStimulus(1'b0, 16'd8, 16'd0, 4'd7, 4'd5, 16'd3);
    for (int i = 0; i < 10; i++) begin
      stepClk();
      checkOutput("dacq_no_trig", {31'd0, o_trig}, 32'd0);
    end
    checkOutput("idle_gain_live", {28'd0, o_gain_sel}, 32'd7);

    // Re-enable: full settle again, then init>=final goes straight to TRACK after one dwell
    i_enable = 1'b1;
    waitTicks(63);
    checkOutput("re_settle63", {30'd0, o_state}, 32'd1);
    waitTicks(1);
    checkOutput("re_settle64", {30'd0, o_state}, 32'd1);
    checkOutput("re_settle_fb", {31'd0, o_fb_ON}, 32'd0);
    stepClk();
    checkOutput("re_acq_state", {30'd0, o_state}, 32'd2);
    checkOutput("re_acq_fb", {31'd0, o_fb_ON}, 32'd1);
    checkOutput("re_acq_gain", {28'd0, o_gain_sel}, 32'd7);
    waitTicks(2);
    stepClk();
    checkOutput("ge_acq_state", {30'd0, o_state}, 32'd2);
    checkOutput("ge_acq_gain", {28'd0, o_gain_sel}, 32'd7);
    waitTicks(1);
    stepClk();
    checkOutput("ge_track_state", {30'd0, o_state}, 32'd3);
    checkOutput("ge_track_gain", {28'd0, o_gain_sel}, 32'd7);
    checkOutput("ge_track_locked", {31'd0, o_locked}, 32'd1);

    i_gain_final = 4'd15;
    waitTicks(2);
    stepClk();
    checkOutput("final_live_state", {30'd0, o_state}, 32'd3);
    checkOutput("final_live_gain", {28'd0, o_gain_sel}, 32'd7);

    // Forced relocks: unlock count 0 and dwell 0 both act as 1, two ticks per relock
    i_gain_final = 4'd5;
    i_err        = 32'd5000;
    i_unlock_cnt = 8'd0;
    i_dwell      = 16'd0;
    i_mod_period = 16'd2;
    waitTicks(400);
    stepClk();
    checkOutput("relock_201", {24'd0, o_relock_cnt}, 32'd201);
    checkOutput("relock_state", {30'd0, o_state}, 32'd3);
    waitTicks(120);
    stepClk();
    checkOutput("relock_sat", {24'd0, o_relock_cnt}, 32'd255);

    // Asynchronous reset in TRACK, checked before the next clock edge
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("arst_trig", {31'd0, o_trig}, 32'd0);
    checkOutput("arst_fb", {31'd0, o_fb_ON}, 32'd0);
    checkOutput("arst_locked", {31'd0, o_locked}, 32'd0);
    checkOutput("arst_state", {30'd0, o_state}, 32'd0);
    checkOutput("arst_relock", {24'd0, o_relock_cnt}, 32'd0);
    checkOutput("arst_gain", {28'd0, o_gain_sel}, 32'd7);
    #5 i_rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
